// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register indices, field positions, exception codes
// and the exception handler entry address.
package cp0_defs;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int unsigned SR_IE        = 0;
  localparam int unsigned SR_EXL       = 1;
  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_BD     = 31;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0 for the P7 pipeline: exception/interrupt arbitration at M,
// SR/Cause/EPC/PRId state and the mfc0/mtc0/eret service paths.
module cp0_unit
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID     = 32'h2023_0007,
  parameter int unsigned HW_INT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         m_pc,
  input  logic [4:0]          m_exc_code,
  input  logic                m_delay_slot,
  input  logic                m_eret,
  input  logic                we,
  input  logic [4:0]          cp0_addr,
  input  logic [31:0]         cp0_wdata,
  input  logic [HW_INT_W-1:0] hw_int,
  output logic [31:0]         cp0_rdata,
  output logic [31:0]         epc_out,
  output logic                req
);

  logic [HW_INT_W-1:0] r_im;
  logic                r_exl;
  logic                r_ie;
  logic                r_bd;
  logic [HW_INT_W-1:0] r_ip;
  logic [4:0]          r_exc_code;
  logic [31:0]         r_epc;

  logic                w_int_req;
  logic                w_exc_req;
  logic                w_req;
  logic [31:0]         w_sr;
  logic [31:0]         w_cause;

  // Gating uses the live pins, not the one-cycle-late IP copy.
  assign w_int_req = (|(hw_int & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (m_exc_code != 5'd0) & ~r_exl;
  assign w_req     = w_int_req | w_exc_req;

  assign req     = w_req;
  assign epc_out = r_epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_ip <= hw_int;
      if (w_req) begin
        r_exl      <= 1'b1;
        r_bd       <= m_delay_slot;
        r_exc_code <= w_int_req ? 5'd0 : m_exc_code;
        r_epc      <= m_delay_slot ? (m_pc - 32'd4) : m_pc;
      end else begin
        if (we && (cp0_addr == REG_SR)) begin
          r_im  <= cp0_wdata[SR_IM_LO +: HW_INT_W];
          r_exl <= cp0_wdata[SR_EXL];
          r_ie  <= cp0_wdata[SR_IE];
        end
        if (we && (cp0_addr == REG_EPC)) begin
          r_epc <= cp0_wdata;
        end
        // Placed after the SR write so eret's EXL clear overrides wdata[1].
        if (m_eret) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_sr                             = '0;
    w_sr[SR_IM_LO +: HW_INT_W]       = r_im;
    w_sr[SR_EXL]                     = r_exl;
    w_sr[SR_IE]                      = r_ie;

    w_cause                          = '0;
    w_cause[CAUSE_BD]                = r_bd;
    w_cause[CAUSE_IP_LO +: HW_INT_W] = r_ip;
    w_cause[CAUSE_EXC_LO +: 5]       = r_exc_code;

    case (cp0_addr)
      REG_SR:    cp0_rdata = w_sr;
      REG_CAUSE: cp0_rdata = w_cause;
      REG_EPC:   cp0_rdata = r_epc;
      REG_PRID:  cp0_rdata = PRID;
      default:   cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: expected values are queued as stimulus is
// applied and popped when the matching DUT output is sampled.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_pc;
  logic [4:0]  m_exc_code;
  logic        m_delay_slot;
  logic        m_eret;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata;
  logic [31:0] epc_out;
  logic        req;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] q_exp[$];
  logic [31:0] got;
  logic [31:0] exp_v;

  localparam logic [31:0] PRID_EXP = 32'h2023_0007;

  cp0_unit #(.PRID(32'h2023_0007), .HW_INT_W(6)) dut (
    .clk(clk), .reset(reset), .m_pc(m_pc), .m_exc_code(m_exc_code),
    .m_delay_slot(m_delay_slot), .m_eret(m_eret), .we(we),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .hw_int(hw_int),
    .cp0_rdata(cp0_rdata), .epc_out(epc_out), .req(req)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_exc_code = 5'd0; m_delay_slot = 1'b0; m_eret = 1'b0;
    we = 1'b0; cp0_wdata = '0; m_pc = '0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    cp0_addr = a;
    #1;
    v = cp0_rdata;
  endtask

  task automatic test_reset();
    logic [4:0] addrs [4];
    addrs = '{5'd12, 5'd13, 5'd14, 5'd15};
    q_exp.push_back(32'h0); q_exp.push_back(32'h0);
    q_exp.push_back(32'h0); q_exp.push_back(PRID_EXP);
    foreach (addrs[i]) begin
      rd(addrs[i], got);
      exp_v = q_exp.pop_front();
      checks++;
      if (got !== exp_v) begin failures++; $display("FAIL reset_rd%0d got=%h exp=%h", addrs[i], got, exp_v); end
    end
    q_exp.push_back(32'h0);
    exp_v = q_exp.pop_front(); got = {31'b0, req}; checks++;
    if (got !== exp_v) begin failures++; $display("FAIL reset_req got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_exception();
    logic [4:0] addrs [3];
    cyc();
    m_exc_code = 5'd12; m_pc = 32'h3004; m_delay_slot = 1'b0;
    q_exp.push_back(32'h1);
    #1; got = {31'b0, req}; exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL exc_req got=%h exp=%h", got, exp_v); end
    cyc(); idle();
    addrs = '{5'd12, 5'd13, 5'd14};
    q_exp.push_back(32'h0000_0002); q_exp.push_back(32'h0000_0030); q_exp.push_back(32'h0000_3004);
    foreach (addrs[i]) begin
      rd(addrs[i], got); exp_v = q_exp.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL exc_rd%0d got=%h exp=%h", addrs[i], got, exp_v); end
    end
    m_exc_code = 5'd12; m_pc = 32'h3008;
    q_exp.push_back(32'h0);
    #1; got = {31'b0, req}; exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL exc_nested_req got=%h exp=%h", got, exp_v); end
    cyc(); idle();
    m_eret = 1'b1;
    cyc(); idle();
    q_exp.push_back(32'h0);
    rd(5'd12, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL exc_eret_sr got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_delay_slot();
    cyc();
    m_exc_code = 5'd4; m_pc = 32'h3010; m_delay_slot = 1'b1;
    q_exp.push_back(32'h1);
    #1; got = {31'b0, req}; exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL ds_req got=%h exp=%h", got, exp_v); end
    cyc(); idle();
    q_exp.push_back(32'h8000_0010); q_exp.push_back(32'h0000_300C); q_exp.push_back(32'h0000_300C);
    rd(5'd13, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL ds_cause got=%h exp=%h", got, exp_v); end
    rd(5'd14, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL ds_epc got=%h exp=%h", got, exp_v); end
    got = epc_out; exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL ds_epc_out got=%h exp=%h", got, exp_v); end
    m_eret = 1'b1;
    cyc(); idle();
    m_exc_code = 5'd5; m_pc = 32'h0; m_delay_slot = 1'b1;
    cyc(); idle();
    q_exp.push_back(32'hFFFF_FFFC); q_exp.push_back(32'h8000_0014);
    rd(5'd14, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL ds_wrap_epc got=%h exp=%h", got, exp_v); end
    rd(5'd13, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL ds_wrap_cause got=%h exp=%h", got, exp_v); end
    m_eret = 1'b1;
    cyc(); idle();
  endtask

  task automatic test_interrupt();
    logic [4:0] addrs [3];
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01;
    cyc(); idle();
    q_exp.push_back(32'h0000_FC01);
    rd(5'd12, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL int_sr got=%h exp=%h", got, exp_v); end
    hw_int = 6'b000100; m_exc_code = 5'd10; m_pc = 32'h3020;
    q_exp.push_back(32'h1);
    #1; got = {31'b0, req}; exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL int_req got=%h exp=%h", got, exp_v); end
    cyc(); idle();
    addrs = '{5'd13, 5'd14, 5'd12};
    q_exp.push_back(32'h0000_1000); q_exp.push_back(32'h0000_3020); q_exp.push_back(32'h0000_FC03);
    foreach (addrs[i]) begin
      rd(addrs[i], got); exp_v = q_exp.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL int_rd%0d got=%h exp=%h", addrs[i], got, exp_v); end
    end
    hw_int = 6'b0; m_eret = 1'b1;
    cyc(); idle();
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_EC01;
    cyc(); idle();
    hw_int = 6'b000100;
    q_exp.push_back(32'h0);
    #1; got = {31'b0, req}; exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL int_masked_req got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_conflict_eret();
    cyc();
    m_exc_code = 5'd8; m_pc = 32'h3040; we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h1234;
    q_exp.push_back(32'h1);
    #1; got = {31'b0, req}; exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL cfl_req got=%h exp=%h", got, exp_v); end
    cyc(); idle();
    q_exp.push_back(32'h0000_3040); q_exp.push_back(32'h0000_EC03); q_exp.push_back(32'h0000_1020);
    rd(5'd14, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL cfl_epc got=%h exp=%h", got, exp_v); end
    rd(5'd12, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL cfl_sr got=%h exp=%h", got, exp_v); end
    rd(5'd13, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL cfl_cause got=%h exp=%h", got, exp_v); end
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC03;
    cyc(); idle();
    m_eret = 1'b1;
    q_exp.push_back(32'h0);
    #1; got = {31'b0, req}; exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL cfl_exl_req got=%h exp=%h", got, exp_v); end
    cyc(); idle();
    q_exp.push_back(32'h1); q_exp.push_back(32'h0000_FC01); q_exp.push_back(32'h0);
    got = {31'b0, req}; exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL cfl_post_eret_req got=%h exp=%h", got, exp_v); end
    rd(5'd12, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL cfl_post_eret_sr got=%h exp=%h", got, exp_v); end
    hw_int = 6'b0;
    #1; got = {31'b0, req}; exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL cfl_int_drop_req got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_masking();
    cyc();
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FFFF;
    cyc(); idle();
    q_exp.push_back(32'h0000_FC03);
    rd(5'd12, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL mask_sr got=%h exp=%h", got, exp_v); end
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FFFF; m_eret = 1'b1;
    cyc(); idle();
    q_exp.push_back(32'h0000_FC01);
    rd(5'd12, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL mask_sr_eret got=%h exp=%h", got, exp_v); end
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FFFF;
    cyc(); idle();
    we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
    cyc(); idle();
    we = 1'b1; cp0_addr = 5'd15; cp0_wdata = 32'h0;
    cyc(); idle();
    q_exp.push_back(32'h0000_0020); q_exp.push_back(PRID_EXP); q_exp.push_back(32'h0);
    rd(5'd13, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL mask_cause got=%h exp=%h", got, exp_v); end
    rd(5'd15, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL mask_prid got=%h exp=%h", got, exp_v); end
    rd(5'd3, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL mask_unmapped got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_reset_mid_handler();
    cyc();
    reset = 1'b1; m_exc_code = 5'd12; m_pc = 32'h5000;
    cyc();
    reset = 1'b0; idle();
    q_exp.push_back(32'h0); q_exp.push_back(32'h0); q_exp.push_back(32'h0);
    rd(5'd12, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL rst_mid_sr got=%h exp=%h", got, exp_v); end
    rd(5'd14, got); exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL rst_mid_epc got=%h exp=%h", got, exp_v); end
    got = {31'b0, req}; exp_v = q_exp.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL rst_mid_req got=%h exp=%h", got, exp_v); end
  endtask

  initial begin
    reset = 1'b1; hw_int = '0; cp0_addr = '0; idle();
    cyc();
    reset = 1'b0;
    cyc();
    test_reset();
    test_exception();
    test_delay_slot();
    test_interrupt();
    test_conflict_eret();
    test_masking();
    test_reset_mid_handler();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor 0 for the P7 pipelined MIPS core. Sits at the M stage and consumes the exception sideband that the EX/MEM register delivers: PC, excCode, delay-slot flag, and eret.
- Decides whether an interrupt or exception is taken and drives `req`. `req` flushes all pipeline registers and redirects fetch to the handler.
- Holds SR, Cause, EPC and PRId, and services mfc0/mtc0 and eret.

Parameters:
- PRID, 32'h2023_0007, read-only value returned for register 15.
- HW_INT_W, 6, number of external interrupt lines; maps to IM/IP bits [15:10].

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- m_pc  input  32  PC of the instruction currently in M. For a bubble inserted by stall, this is the held PC.
- m_exc_code  input  5  pending exception code from M; 0 = none
- m_delay_slot  input  1  M instruction (or bubble) is in a branch delay slot
- m_eret  input  1  eret is in M
- we  input  1  mtc0 write enable from M
- cp0_addr  input  5  register index for mfc0/mtc0
- cp0_wdata  input  32  mtc0 write data
- hw_int  input  HW_INT_W  external interrupt request lines, level-sensitive
- cp0_rdata  output  32  mfc0 read data, combinational
- epc_out  output  32  current EPC value, used by fetch on eret
- req  output  1  take exception/interrupt this cycle; combinational

Behaviour:
- State:
  - SR{IM[15:10], EXL[1], IE[0]}; all other SR bits read 0.
  - Cause{BD[31], IP[15:10], ExcCode[6:2]}; all other bits read 0.
  - EPC[31:0].
- Reset (sync, active-high): SR=0, Cause=0, EPC=0. Therefore IE=0 and `req`=0 provided m_exc_code=0.
  - Reset wins over every other event in the same cycle, including mid-handler (EXL=1): EXL returns to 0.
- Request logic (combinational, same cycle):
  - int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL
  - exc_req = (m_exc_code != 0) & ~SR.EXL
  - req = int_req | exc_req
- On the clock edge with req=1:
  - EXL<=1.
  - Cause.BD<=m_delay_slot.
  - Cause.ExcCode<=int_req ? 5'd0 : m_exc_code. Interrupt has priority over a simultaneous exception.
  - EPC<=m_delay_slot ? (m_pc-4) : m_pc, with 32-bit wrap. m_pc=0 with BD=1 gives 32'hFFFF_FFFC.
  - Any concurrent mtc0 is discarded.
  - Any concurrent eret is ignored. It cannot actually occur, because eret only reaches M with EXL=1.
- Cause.IP is loaded from hw_int every cycle, regardless of req or reset release; this gives a 1-cycle lag versus the pin. Gating uses the live hw_int, not IP.
- eret (m_eret=1, req=0): EXL<=0 on the edge.
- mtc0 (we=1, req=0):
  - addr 12: SR<= wdata with bits [15:10], [1], [0] kept and all others masked.
  - addr 14: EPC<=wdata.
  - addr 13, addr 15 and all other addresses: no effect.
- mtc0 to SR and eret in the same cycle: both apply; eret's EXL clear overrides wdata[1].
- Read path (combinational, sees pre-edge values):
  - addr 12/13/14/15 returns SR/Cause/EPC/PRID respectively.
  - Any other address returns 0.
- Latency: req is asserted in the same cycle as the triggering condition. Register updates are visible to mfc0 from the next cycle.
- `epc_out` = EPC register, combinational.
- No hidden state beyond SR/Cause/EPC; no FSM beyond the EXL bit (normal ↔ in-handler).

Decomposition:
- Shared package `cp0_defs`:
  - register indices: SR=12, CAUSE=13, EPC=14, PRID=15
  - SR/Cause bit positions
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12, Syscall=8
  - handler address 32'h0000_4180
- No sub-module; a single block of roughly 150-200 lines.

Test Plan:
- Reset check: assert reset 1 cycle. Then cp0_rdata returns 0 for SR, Cause and EPC, returns PRID for 15, and req=0.
- Exception capture: m_exc_code=12 (Ov), m_pc=32'h3004, m_delay_slot=0, EXL=0.
  - req=1 that cycle.
  - Next cycle: EPC=32'h3004, ExcCode=12, BD=0, EXL=1.
  - A second exc with EXL=1 gives req=0.
- Delay-slot exception: m_exc_code=4, m_pc=32'h3010, m_delay_slot=1 → EPC=32'h300C, BD=1.
- Interrupt enable and priority:
  - mtc0 SR=32'h0000_FC01 (IM all on, IE=1).
  - Then hw_int=6'b000100 together with m_exc_code=10, m_pc=32'h3020.
  - Result: req=1, ExcCode=0, EPC=32'h3020.
  - With IM[12]=0, the same hw_int gives req=0.
- Conflict and eret:
  - mtc0 EPC=32'h1234 in the same cycle as an exception → EPC=m_pc, write dropped.
  - Later m_eret=1 → EXL=0 next cycle.
  - A pending interrupt then raises req=1 immediately.
- Write masking: mtc0 SR=32'hFFFF_FFFF reads back 32'h0000_FC03. mtc0 to Cause leaves Cause unchanged.
